store_buffer: RTL
=================

# store_buffer

Store-side companion to the register file's load-byte writeback path: accepts `sb`/`sh`/`sw` stores from the execute stage, aligns store data onto byte lanes with byte enables, queues them in a small FIFO, and drains them to the data memory over a req/ack handshake. It sits between the ALU result/rt read port and the data memory write port. It also flags load-after-store hazards against pending entries. Lane order matches the load path: byte offset 00 → bits 7:0, 11 → bits 31:24.

## Interface
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `clk  in  1`  clock, rising edge
- `rst  in  1`  reset, asynchronous, active-high
- `st_valid  in  1`  store request this cycle
- `op  in  6`  instruction opcode (101000 sb, 101001 sh, 101011 sw; others ignored)
- `addr  in  32`  effective address (ALU result)
- `rt_data  in  32`  store source register value
- `st_ready  out  1`  FIFO can accept (`count != DEPTH`)
- `misalign  out  1`  combinational: valid store with illegal alignment
- `mem_req  out  1`  registered: memory write request
- `mem_addr  out  30`  registered word address [31:2]
- `mem_wdata  out  32`  registered lane-aligned data
- `mem_be  out  4`  registered byte enables
- `mem_ack  in  1`  memory accepted current request
- `ld_check  in  1`  a load is in execute
- `ld_addr  in  30`  load word address [31:2]
- `ld_hazard  out  1`  combinational: pending store matches `ld_addr`
- `empty  out  1`  no entries and no request outstanding
- `count  out  $clog2(DEPTH+1)`  entries held, including the one being issued

## Operation
- Enqueue on rising edge when `st_valid && st_ready && is_store(op) && !misalign`. Non-store ops and misaligned stores are dropped; nothing enqueued.
- Alignment: sb any offset; sh legal at `addr[1:0]` ∈ {00,10}; sw legal only at 00. `misalign = st_valid && is_store(op) && illegal`.
- Lane mapping: sb → wdata `{4{rt[7:0]}}`, be `4'b0001 << addr[1:0]`; sh → wdata `{2{rt[15:0]}}`, be 0011 (off 00) or 1100 (off 10); sw → wdata `rt`, be 1111.
- Entry stores {addr[31:2], wdata, be}; FIFO uses head/tail pointers wrapping mod DEPTH.
- Drain FSM, two states:
  - IDLE: `mem_req=0`. If `count>0`, load head into `mem_*` registers, assert `mem_req`, go ISSUE.
  - ISSUE: hold `mem_*` stable until `mem_ack`. On ack pop head; if entries remain (count after pop >0), load next head same edge and stay ISSUE (`mem_req` stays 1); else deassert, go IDLE.
- `mem_ack` while `mem_req=0` is ignored.
- Full: `st_ready=0` even if a pop occurs the same cycle (no bypass of full).
- Simultaneous enqueue and pop when not full: both take effect; count unchanged.
- `ld_hazard = ld_check && any valid entry (including the issuing head) has addr == ld_addr`. Word granularity; byte lanes not compared.
- Reset: FIFO flushed, pointers and count 0, state IDLE, `mem_req=0`, `mem_addr/mem_wdata/mem_be=0`, `empty=1`, `st_ready=1`. Reset mid-ISSUE drops the outstanding request immediately; memory must tolerate an abandoned request.

## Timing
- Store accepted at edge N → `mem_req` high after edge N+1 (if FIFO was empty and IDLE).
- Ack at edge M with more entries → next request valid after edge M (back-to-back, one store per cycle throughput).
- `misalign`, `ld_hazard`, `st_ready` combinational from inputs/current state; no registered delay.
- `count`, `empty` update on the edge of enqueue/pop.

## Structure
- Shared package `cpu_pkg`: opcode constants OP_SB, OP_SH, OP_SW (and existing OP_LB, OP_LBU), FSM state typedef `sb_state_t` {IDLE, ISSUE}.
- Sub-module `store_align`: combinational op/addr/rt → {wdata, be, misalign}; instantiated once at the input.

## Test plan
- Reset, then sb op=101000 addr=0x0000_1003 rt=0x0000_00A5 → after 2 edges mem_req=1, mem_addr=0x400, mem_be=1000, mem_wdata=0xA5A5_A5A5; ack → empty=1.
- sh at addr 0x…01 → misalign=1, count stays 0; sw at 0x…02 → misalign=1; sh at 0x…02 rt=0x1234 → be=1100, wdata=0x1234_1234.
- Enqueue 4 sw with mem_ack=0 → count=4, st_ready=0, 5th store dropped; then ack every cycle → 4 consecutive requests in FIFO order, mem_req continuous.
- With entry addr 0x2000 pending, ld_check=1 ld_addr=0x800 → ld_hazard=1; ld_addr=0x801 → 0; after ack → 0.
- Enqueue and ack same cycle at count=2 → count stays 2, order preserved.
- Assert rst during ISSUE with count=3 → mem_req=0 immediately, count=0, subsequent mem_ack ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-op opcodes, store-buffer FSM state, queued store entry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sb_state_t;

  // One queued store: word address plus lane-aligned data and byte enables.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane aligner: replicates store data across byte lanes and builds byte enables.
// Latency: purely combinational.
// Backpressure: none; flags illegal alignment for the caller to drop the store.
module store_align
  import cpu_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rt_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        illegal_o
);

  // Lane placement follows the load path: offset 00 is bits 7:0.
  always_comb begin
    wdata_o   = rt_i;
    be_o      = 4'b0000;
    illegal_o = 1'b0;
    case (op_i)
      OP_SB: begin
        wdata_o = {4{rt_i[7:0]}};
        be_o    = 4'b0001 << off_i;
      end
      OP_SH: begin
        wdata_o   = {2{rt_i[15:0]}};
        be_o      = off_i[1] ? 4'b1100 : 4'b0011;
        illegal_o = off_i[0];
      end
      OP_SW: begin
        be_o      = 4'b1111;
        illegal_o = |off_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues aligned stores and drains them to data memory over req/ack.
// Latency: accepted store reaches mem_req one edge later when idle; back-to-back on ack.
// Backpressure: st_ready drops when DEPTH entries are held (issuing head included).
module store_buffer
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [5:0]    op,
  input  logic [31:0]   addr,
  input  logic [31:0]   rt_data,
  output logic          st_ready,
  output logic          misalign,
  output logic          mem_req,
  output logic [29:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic          ld_check,
  input  logic [29:0]   ld_addr,
  output logic          ld_hazard,
  output logic          empty,
  output logic [CW-1:0] count
);

  sb_entry_t       fifo_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  sb_state_t       state_q;
  sb_entry_t       mem_q;
  logic            req_q;

  logic [31:0]     al_wdata;
  logic [3:0]      al_be;
  logic            al_illegal;
  logic            push, pop;
  sb_entry_t       new_entry;
  logic            hazard_any;
  logic [PW-1:0]   slot;

  store_align u_align (
    .op_i      (op),
    .off_i     (addr[1:0]),
    .rt_i      (rt_data),
    .wdata_o   (al_wdata),
    .be_o      (al_be),
    .illegal_o (al_illegal)
  );

  // The issuing head stays counted until acked, so full cannot be bypassed by a same-cycle pop.
  assign st_ready  = (count_q != CW'(DEPTH));
  assign misalign  = st_valid && is_store(op) && al_illegal;
  assign push      = st_valid && st_ready && is_store(op) && !al_illegal;
  assign pop       = (state_q == ISSUE) && mem_ack;
  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign new_entry = '{addr: addr[31:2], wdata: al_wdata, be: al_be};

  // Word-granular match of the load address against every occupied slot.
  always_comb begin
    hazard_any = 1'b0;
    slot       = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PW'(k);
      if ((CW'(k) < count_q) && (fifo_q[slot].addr == ld_addr)) begin
        hazard_any = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_check && hazard_any;

  // FIFO storage and pointers; enqueue and pop may happen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[tail_q] <= new_entry;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Drain FSM: present the head, hold it until ack, then chain the next head with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            mem_q   <= fifo_q[head_q];
            req_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            if (count_q > CW'(1)) begin
              mem_q <= fifo_q[head_q + PW'(1)];
            end else begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign mem_be    = mem_q.be;
  assign count     = count_q;
  assign empty     = (count_q == '0) && !req_q;

endmodule
